step_bcd_counter: RTL and testbench

- Counts maze-solver moves in 4-digit packed BCD and supplies the digit values and leading-zero blanking to the 4-digit seven-segment multiplexer.
- Sits directly upstream of the display stage, in the main system clock domain. The display stage samples its outputs at the refresh rate.
- Freezes the count when the solver reports completion. Saturates at the maximum displayable value.

---
 rtl/step_bcd_counter.sv | 133 +++++++++++++
 tb/tb_step_bcd_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_bcd_counter.sv
// rtl/step_bcd_counter.sv - 4-digit packed BCD move counter with freeze, saturation and leading-zero blanking
//
// Ports:
//   clk          system clock
//   clr          synchronous active-high reset, highest priority
//   step         move indication, level; each rising edge counts one move
//   solved       level, high once the maze exit is reached; freezes the count
//   clear_count  synchronous soft clear of count, overflow and freeze
//   digits       packed BCD count, [15:12] leftmost digit
//   blank        per-digit leading-zero blank request, bit3 leftmost; bit0 always 0
//   overflow     sticky, set when a step arrives while the count is saturated
//   frozen       high while the count is frozen after completion
module step_bcd_counter #(
    parameter int                      NUM_DIGITS    = 4,
    parameter logic [4*NUM_DIGITS-1:0] MAX_COUNT_BCD = 16'h9999
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    step,
    input  logic                    solved,
    input  logic                    clear_count,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    overflow,
    output logic                    frozen
);

    localparam int W = 4 * NUM_DIGITS;

    // With a zero count every digit but the rightmost is a leading zero.
    localparam logic [NUM_DIGITS-1:0] BLANK_ZERO = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic {
        COUNTING = 1'b0,
        FROZEN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          digits_q, digits_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  overflow_q, overflow_d;
    logic                  step_q;      // previous sample of step for edge detection
    logic                  step_rise;

    // Single-cycle BCD ripple increment; a 9 wraps to 0 and carries upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign step_rise = step & ~step_q;

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        if (clear_count) begin
            // A step edge coinciding with the clear is dropped.
            state_d    = COUNTING;
            digits_d   = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                COUNTING: begin
                    if (step_rise) begin
                        if (digits_q == MAX_COUNT_BCD) begin
                            overflow_d = 1'b1;
                        end else begin
                            digits_d = bcd_inc(digits_q);
                        end
                    end
                    // The final move is counted on the same edge that freezes.
                    if (solved) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    state_d = FROZEN;
                end
                default: begin
                    state_d = COUNTING;
                end
            endcase
        end
    end

    // Blank is derived from the next count so it lines up with digits.
    always_comb begin
        logic zero_above;
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (digits_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= COUNTING;
            digits_q   <= '0;
            blank_q    <= BLANK_ZERO;
            overflow_q <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            step_q     <= step;
        end
    end

    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;
    assign frozen   = (state_q == FROZEN);

endmodule

// File: tb/tb_step_bcd_counter.sv
// tb/tb_step_bcd_counter.sv - self-checking bench for step_bcd_counter
module tb_step_bcd_counter;

    logic        clk;
    logic        clr;
    logic        step;
    logic        solved;
    logic        clear_count;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        overflow;
    logic        frozen;

    int checks   = 0;
    int failures = 0;

    step_bcd_counter dut (
        .clk         (clk),
        .clr         (clr),
        .step        (step),
        .solved      (solved),
        .clear_count (clear_count),
        .digits      (digits),
        .blank       (blank),
        .overflow    (overflow),
        .frozen      (frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        ovf;
        logic        frz;
    } exp_t;

    typedef struct {
        logic        clr;
        logic        step;
        logic        solved;
        logic        clear;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        ovf;
        logic        frz;
    } vec_t;

    exp_t sb_q[$];

    // Reference model kept as a plain integer count.
    int   m_count;
    logic m_ovf, m_frz, m_stepd;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [3:0] to_blank(input int n);
        return {n < 1000, n < 100, n < 10, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one clock cycle, queue its expectation, compare after the edge.
    task automatic apply(input logic c, input logic s, input logic sv, input logic cc, input exp_t e);
        exp_t got;
        clr         = c;
        step        = s;
        solved      = sv;
        clear_count = cc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("digits", digits, got.digits);
        chk("blank", {12'h0, blank}, {12'h0, got.blank});
        chk("overflow", {15'h0, overflow}, {15'h0, got.ovf});
        chk("frozen", {15'h0, frozen}, {15'h0, got.frz});
    endtask

    task automatic cyc(input logic c, input logic s, input logic sv, input logic cc);
        exp_t e;
        logic rise;
        if (c) begin
            m_count = 0; m_ovf = 0; m_frz = 0; m_stepd = 0;
        end else begin
            rise    = s & ~m_stepd;
            m_stepd = s;
            if (cc) begin
                m_count = 0; m_ovf = 0; m_frz = 0;
            end else if (!m_frz) begin
                if (rise) begin
                    if (m_count == 9999) m_ovf = 1'b1;
                    else m_count++;
                end
                if (sv) m_frz = 1'b1;
            end
        end
        e.digits = to_bcd(m_count);
        e.blank  = to_blank(m_count);
        e.ovf    = m_ovf;
        e.frz    = m_frz;
        apply(c, s, sv, cc, e);
    endtask

    task automatic pulses(input int n, input int lo, input logic sv);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, sv, 1'b0);
            for (int j = 0; j < lo; j++) cyc(1'b0, 1'b0, sv, 1'b0);
        end
    endtask

    vec_t vt[15];

    initial begin
        clr = 1'b1; step = 1'b0; solved = 1'b0; clear_count = 1'b0;
        m_count = 0; m_ovf = 0; m_frz = 0; m_stepd = 0;

        //          clr   step  solv  clr_c digits    blank    ovf   frz
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 4'b1110, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b1};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'b1110, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1110, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            exp_t e;
            e.digits = vt[i].digits;
            e.blank  = vt[i].blank;
            e.ovf    = vt[i].ovf;
            e.frz    = vt[i].frz;
            apply(vt[i].clr, vt[i].step, vt[i].solved, vt[i].clear, e);
        end

        // Twelve separate pulses.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(12, 3, 1'b0);
        chk("twelve_digits", digits, 16'h0012);
        chk("twelve_blank", {12'h0, blank}, 16'h000c);

        // Held step counts once.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_digits", digits, 16'h0001);

        // Carry boundaries and saturation.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(99, 1, 1'b0);
        chk("pre_0099", digits, 16'h0099);
        pulses(1, 1, 1'b0);
        chk("carry_0100", digits, 16'h0100);
        chk("carry_0100_blank", {12'h0, blank}, 16'h0008);
        pulses(899, 1, 1'b0);
        chk("pre_0999", digits, 16'h0999);
        pulses(1, 1, 1'b0);
        chk("carry_1000", digits, 16'h1000);
        chk("carry_1000_blank", {12'h0, blank}, 16'h0000);
        pulses(8999, 1, 1'b0);
        chk("sat_9999", digits, 16'h9999);
        chk("sat_no_ovf", {15'h0, overflow}, 16'h0000);
        pulses(1, 1, 1'b0);
        chk("sat_ovf_first", {15'h0, overflow}, 16'h0001);
        pulses(2, 1, 1'b0);
        chk("sat_hold", digits, 16'h9999);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_digits", digits, 16'h0000);
        chk("clear_ovf", {15'h0, overflow}, 16'h0000);

        // Final move together with solved, then frozen.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(41, 1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("final_move", digits, 16'h0042);
        chk("final_frozen", {15'h0, frozen}, 16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        pulses(5, 2, 1'b0);
        chk("frozen_hold", digits, 16'h0042);
        chk("frozen_stays", {15'h0, frozen}, 16'h0001);

        // Clear coinciding with a rising step held afterwards.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(3, 1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_held", digits, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clear_rerise", digits, 16'h0001);

        // Reset in the middle of a count.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(357, 1, 1'b0);
        chk("pre_0357", digits, 16'h0357);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midclr_digits", digits, 16'h0000);
        chk("midclr_blank", {12'h0, blank}, 16'h000e);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(1, 1, 1'b0);
        chk("midclr_first", digits, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
